// File: rtl/snake_direction_controller.sv
// rtl/snake_direction_controller.sv - push-button to committed snake heading
// Per-key sync/debounce/press detect, request arbitration and tick-aligned commit.
module snake_direction_controller #(
  parameter int         CLOCK_FREQ  = 50000000,
  parameter int         DEBOUNCE_MS = 10,
  parameter logic [1:0] INIT_DIR    = 2'b11
) (
  input  logic       clock,
  input  logic       resetHW,
  input  logic [3:0] keys,
  input  logic       gameTick,
  input  logic       collision,
  output logic [1:0] direction,
  output logic       directionUp,
  output logic       directionDown,
  output logic       directionLeft,
  output logic       directionRight,
  output logic       keyEvent
);

  localparam int DEBOUNCE_CYCLES = CLOCK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       stable;
  logic [3:0]       stable_d;
  logic [3:0]       armed;
  logic [1:0]       warm;
  logic [CNT_W-1:0] cnt [4];

  logic [3:0] press;
  logic [1:0] req;
  logic       has_req;
  logic [1:0] ref_dir;
  logic       commit;
  logic       accept;

  logic [1:0] pending;
  logic       pend_valid;
  logic [3:0] dir_onehot;

  function automatic logic [3:0] onehot_of(input logic [1:0] d);
    case (d)
      2'b00:   onehot_of = 4'b1000;
      2'b01:   onehot_of = 4'b0100;
      2'b10:   onehot_of = 4'b0010;
      default: onehot_of = 4'b0001;
    endcase
  endfunction

  // A key is armed only once it has been seen released after the synchroniser
  // has flushed its reset value, so a key held through reset never fires.
  always_ff @(posedge clock or negedge resetHW) begin
    if (!resetHW) begin
      sync1    <= '1;
      sync2    <= '1;
      stable   <= '1;
      stable_d <= '1;
      armed    <= '0;
      warm     <= '0;
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else begin
      sync1    <= keys;
      sync2    <= sync1;
      stable_d <= stable;
      if (warm != 2'd2) warm <= warm + 2'd1;
      for (int k = 0; k < 4; k++) begin
        if (warm == 2'd2 && sync2[k] && stable[k]) armed[k] <= 1'b1;
        if (sync2[k] != stable[k]) begin
          if (cnt[k] == CNT_LAST) begin
            stable[k] <= sync2[k];
            cnt[k]    <= '0;
          end else begin
            cnt[k] <= cnt[k] + 1'b1;
          end
        end else begin
          cnt[k] <= '0;
        end
      end
    end
  end

  always_comb begin
    press   = stable_d & ~stable & armed;
    has_req = |press;
    req     = 2'b11;
    if (press[3])      req = 2'b00;
    else if (press[2]) req = 2'b01;
    else if (press[1]) req = 2'b10;
    commit  = gameTick && pend_valid;
    ref_dir = commit ? pending : direction;
    accept  = has_req && (req != ref_dir) && (req != {ref_dir[1], ~ref_dir[0]});
  end

  always_ff @(posedge clock or negedge resetHW) begin
    if (!resetHW) begin
      direction  <= INIT_DIR;
      dir_onehot <= onehot_of(INIT_DIR);
      pending    <= INIT_DIR;
      pend_valid <= 1'b0;
      keyEvent   <= 1'b0;
    end else if (collision) begin
      pend_valid <= 1'b0;
      keyEvent   <= 1'b0;
    end else begin
      keyEvent <= accept;
      if (commit) begin
        direction  <= pending;
        dir_onehot <= onehot_of(pending);
        pend_valid <= 1'b0;
      end
      if (accept) begin
        pending    <= req;
        pend_valid <= 1'b1;
      end
    end
  end

  assign directionUp    = dir_onehot[3];
  assign directionDown  = dir_onehot[2];
  assign directionLeft  = dir_onehot[1];
  assign directionRight = dir_onehot[0];

endmodule
